// File: rtl/elm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : elm_pkg
// Purpose  : Shared definitions for the ELM hidden-layer sequencer: FSM state
//            encoding and counter-width helpers.
// Ports    : (package, no ports)
// Revision : 1.0 - initial release
// ============================================================================
package elm_pkg;

    // Layer sequencer phases.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    // Width of a counter that must hold 0..num_in inclusive (the extra value
    // is the bias slot that follows the weights of each neuron).
    function automatic int cnt_width(input int num_in);
        return $clog2(num_in + 1);
    endfunction

    // Width of a neuron index; never narrower than one bit so a single-neuron
    // layer still has a legal vector.
    function automatic int nrn_width(input int num_neuron);
        return (num_neuron > 1) ? $clog2(num_neuron) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/elm_out_capture.sv
`default_nettype none
// ============================================================================
// Module   : elm_out_capture
// Purpose  : Collects one activation per neuron while the layer computes,
//            tracks which neurons have reported, then drains the captured
//            activations in neuron order on a valid/ready stream.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            capture_en      - neurons may report this cycle
//            clear_done      - forget which neurons reported
//            nrn_outvalid    - per-neuron result strobe
//            nrn_out         - packed per-neuron results
//            all_done        - every neuron has reported
//            drain_en        - present captured results downstream
//            out_ready       - downstream accepts
//            out_valid/out_data/out_last - activation stream
//            drain_done      - final beat accepted this cycle
// Revision : 1.0 - initial release
// ============================================================================
module elm_out_capture
    import elm_pkg::*;
#(
    parameter int OUT_W      = 8,
    parameter int NUM_NEURON = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        capture_en,
    input  logic                        clear_done,
    input  logic [NUM_NEURON-1:0]       nrn_outvalid,
    input  logic [NUM_NEURON*OUT_W-1:0] nrn_out,
    output logic                        all_done,
    input  logic                        drain_en,
    input  logic                        out_ready,
    output logic                        out_valid,
    output logic [OUT_W-1:0]            out_data,
    output logic                        out_last,
    output logic                        drain_done
);

    localparam int               NRN_W  = nrn_width(NUM_NEURON);
    localparam logic [NRN_W-1:0] LAST_K = NRN_W'(NUM_NEURON - 1);

    logic [NUM_NEURON-1:0] done;
    logic [OUT_W-1:0]      cap [NUM_NEURON];
    logic [NRN_W-1:0]      k;
    logic                  beat;
    logic                  k_is_last;

    // A neuron may raise outvalid more than once; the latest value wins and
    // its done bit simply stays set.
    always_ff @(posedge clk) begin
        if (rst) begin
            done <= '0;
            for (int i = 0; i < NUM_NEURON; i++) begin
                cap[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_NEURON; i++) begin
                if (capture_en && nrn_outvalid[i]) begin
                    cap[i] <= nrn_out[i*OUT_W +: OUT_W];
                end
            end
            if (clear_done) begin
                done <= '0;
            end else if (capture_en) begin
                done <= done | nrn_outvalid;
            end
        end
    end

    assign all_done  = &done;
    assign k_is_last = (k == LAST_K);

    // Output stream: valid for the whole drain phase, data held until taken.
    // Outside the drain the data bus is forced to zero so stale results do
    // not leak onto the stream.
    assign out_valid  = drain_en;
    assign out_last   = drain_en && k_is_last;
    assign beat       = out_valid && out_ready;
    assign drain_done = beat && k_is_last;

    always_comb begin
        out_data = '0;
        if (drain_en) begin
            out_data = cap[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k <= '0;
        end else if (beat) begin
            k <= k_is_last ? '0 : k + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/elm_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : elm_layer_sequencer
// Purpose  : Controls one hidden layer of neurons. LOAD streams NUM_IN weights
//            and one bias per neuron into the array; RUN broadcasts one input
//            vector; WAIT collects every neuron's activation; DRAIN emits the
//            activations in neuron order.
// Ports    : clk, rst                      - clock, sync active-high reset
//            cfg_valid/cfg_ready/cfg_data  - weight/bias config stream
//            in_valid/in_ready/in_data     - feature stream
//            out_valid/out_ready/out_data/out_last - activation stream
//            weight_valid/weight_value     - weight write strobe to neurons
//            config_layer_num/config_neuron_num - neuron select for weights
//            bias_valid/bias_value         - one-hot bias write to neurons
//            nrn_in_valid/nrn_in_data      - feature broadcast to neurons
//            nrn_outvalid/nrn_out          - per-neuron results
//            loaded                        - weights and biases complete
//            busy                          - sequencer not idle
// Revision : 1.0 - initial release
// ============================================================================
module elm_layer_sequencer
    import elm_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int OUT_W      = 8,
    parameter int NUM_IN     = 128,
    parameter int NUM_NEURON = 64,
    parameter int LAYER_NO   = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [DATA_W-1:0]           cfg_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OUT_W-1:0]            out_data,
    output logic                        out_last,
    output logic                        weight_valid,
    output logic [DATA_W-1:0]           weight_value,
    output logic [2*DATA_W:0]           config_layer_num,
    output logic [2*DATA_W:0]           config_neuron_num,
    output logic [NUM_NEURON-1:0]       bias_valid,
    output logic [DATA_W-1:0]           bias_value,
    output logic                        nrn_in_valid,
    output logic [DATA_W-1:0]           nrn_in_data,
    input  logic [NUM_NEURON-1:0]       nrn_outvalid,
    input  logic [NUM_NEURON*OUT_W-1:0] nrn_out,
    output logic                        loaded,
    output logic                        busy
);

    localparam int               CNT_W   = cnt_width(NUM_IN);
    localparam int               NRN_W   = nrn_width(NUM_NEURON);
    localparam int               SEL_W   = 2*DATA_W + 1;
    localparam logic [CNT_W-1:0] BIAS_SLOT = CNT_W'(NUM_IN);
    localparam logic [CNT_W-1:0] LAST_IN   = CNT_W'(NUM_IN - 1);
    localparam logic [NRN_W-1:0] LAST_N    = NRN_W'(NUM_NEURON - 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] w_cnt;
    logic [NRN_W-1:0] n_cnt;
    logic [CNT_W-1:0] in_cnt;

    logic cfg_fire;
    logic in_fire;
    logic is_bias;
    logic load_last;
    logic run_last;
    logic all_done;
    logic drain_done;
    logic in_wait;
    logic in_drain;

    // Handshakes are derived from the state directly (not from the ready
    // outputs) so the next-state logic has no combinational feedback.
    assign cfg_fire  = cfg_valid && (state == ST_LOAD);
    assign in_fire   = in_valid  && (state == ST_RUN);
    assign is_bias   = (w_cnt == BIAS_SLOT);
    assign load_last = cfg_fire && is_bias && (n_cnt == LAST_N);
    assign run_last  = in_fire && (in_cnt == LAST_IN);
    assign in_wait   = (state == ST_WAIT);
    assign in_drain  = (state == ST_DRAIN);

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        cfg_ready  = 1'b0;
        in_ready   = 1'b0;
        busy       = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                // Configuration always wins over a pending input vector.
                if (cfg_valid) begin
                    next_state = ST_LOAD;
                end else if (loaded && in_valid) begin
                    next_state = ST_RUN;
                end
            end
            ST_LOAD: begin
                cfg_ready = 1'b1;
                if (load_last) begin
                    next_state = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Leaving immediately after the last word guarantees a gap
                // on nrn_in_valid between vectors.
                in_ready = 1'b1;
                if (run_last) begin
                    next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (all_done) begin
                    next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_done) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Counters and registered neuron-side strobes
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            w_cnt             <= '0;
            n_cnt             <= '0;
            in_cnt            <= '0;
            loaded            <= 1'b0;
            weight_valid      <= 1'b0;
            weight_value      <= '0;
            config_layer_num  <= '0;
            config_neuron_num <= '0;
            bias_valid        <= '0;
            bias_value        <= '0;
            nrn_in_valid      <= 1'b0;
            nrn_in_data       <= '0;
        end else begin
            // Strobes are single-cycle pulses.
            weight_valid <= 1'b0;
            bias_valid   <= '0;
            nrn_in_valid <= 1'b0;

            // A new load invalidates whatever the neurons held before and
            // always restarts from neuron 0.
            if ((state == ST_IDLE) && cfg_valid) begin
                loaded <= 1'b0;
                w_cnt  <= '0;
                n_cnt  <= '0;
            end

            if (cfg_fire) begin
                if (is_bias) begin
                    bias_valid <= NUM_NEURON'(1) << n_cnt;
                    bias_value <= cfg_data;
                    w_cnt      <= '0;
                    if (n_cnt == LAST_N) begin
                        n_cnt  <= '0;
                        loaded <= 1'b1;
                    end else begin
                        n_cnt <= n_cnt + 1'b1;
                    end
                end else begin
                    weight_valid      <= 1'b1;
                    weight_value      <= cfg_data;
                    config_neuron_num <= SEL_W'(n_cnt);
                    config_layer_num  <= SEL_W'(LAYER_NO);
                    w_cnt             <= w_cnt + 1'b1;
                end
            end

            if (in_fire) begin
                nrn_in_valid <= 1'b1;
                nrn_in_data  <= in_data;
                in_cnt       <= run_last ? '0 : in_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Result capture and output stream
    // ------------------------------------------------------------------------
    elm_out_capture #(
        .OUT_W      (OUT_W),
        .NUM_NEURON (NUM_NEURON)
    ) u_capture (
        .clk          (clk),
        .rst          (rst),
        .capture_en   (in_wait),
        .clear_done   (in_wait && all_done),
        .nrn_outvalid (nrn_outvalid),
        .nrn_out      (nrn_out),
        .all_done     (all_done),
        .drain_en     (in_drain),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_last     (out_last),
        .drain_done   (drain_done)
    );

endmodule
`default_nettype wire

// File: tb/tb_elm_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_elm_layer_sequencer
// Purpose  : Self-checking bench for elm_layer_sequencer with NUM_IN=4,
//            NUM_NEURON=3 and bench-driven stub neurons.
// Revision : 1.0 - initial release
// ============================================================================
module tb_elm_layer_sequencer;

    localparam int DATA_W     = 16;
    localparam int OUT_W      = 8;
    localparam int NUM_IN     = 4;
    localparam int NUM_NEURON = 3;
    localparam int LAYER_NO   = 1;
    localparam int SEL_W      = 2*DATA_W + 1;
    localparam int WORDS      = NUM_NEURON*(NUM_IN + 1);
    localparam int BUS_W      = NUM_NEURON*OUT_W;

    typedef logic [DATA_W-1:0] cfg_t [WORDS];
    typedef logic [DATA_W-1:0] vec_t [NUM_IN];
    typedef logic [OUT_W-1:0]  act_t [NUM_NEURON];

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  cfg_valid, cfg_ready;
    logic [DATA_W-1:0]     cfg_data;
    logic                  in_valid, in_ready;
    logic [DATA_W-1:0]     in_data;
    logic                  out_valid, out_ready, out_last;
    logic [OUT_W-1:0]      out_data;
    logic                  weight_valid;
    logic [DATA_W-1:0]     weight_value;
    logic [SEL_W-1:0]      config_layer_num, config_neuron_num;
    logic [NUM_NEURON-1:0] bias_valid;
    logic [DATA_W-1:0]     bias_value;
    logic                  nrn_in_valid;
    logic [DATA_W-1:0]     nrn_in_data;
    logic [NUM_NEURON-1:0] nrn_outvalid;
    logic [BUS_W-1:0]      nrn_out;
    logic                  loaded, busy;

    elm_layer_sequencer #(
        .DATA_W(DATA_W), .OUT_W(OUT_W), .NUM_IN(NUM_IN),
        .NUM_NEURON(NUM_NEURON), .LAYER_NO(LAYER_NO)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .weight_valid(weight_valid), .weight_value(weight_value),
        .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
        .bias_valid(bias_valid), .bias_value(bias_value),
        .nrn_in_valid(nrn_in_valid), .nrn_in_data(nrn_in_data),
        .nrn_outvalid(nrn_outvalid), .nrn_out(nrn_out),
        .loaded(loaded), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Observed neuron-side and output-side events, sampled mid-cycle.
    logic [SEL_W-1:0]      wv_nrn_q[$];
    logic [SEL_W-1:0]      wv_lay_q[$];
    logic [DATA_W-1:0]     wv_val_q[$];
    logic [NUM_NEURON-1:0] bv_vec_q[$];
    logic [DATA_W-1:0]     bv_val_q[$];
    logic [DATA_W-1:0]     ni_q[$];
    logic [OUT_W-1:0]      od_q[$];
    logic                  ol_q[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (weight_valid) begin
                wv_nrn_q.push_back(config_neuron_num);
                wv_lay_q.push_back(config_layer_num);
                wv_val_q.push_back(weight_value);
            end
            if (bias_valid != '0) begin
                bv_vec_q.push_back(bias_valid);
                bv_val_q.push_back(bias_value);
            end
            if (nrn_in_valid) ni_q.push_back(nrn_in_data);
            if (out_valid && out_ready) begin
                od_q.push_back(out_data);
                ol_q.push_back(out_last);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wv_nrn_q.delete(); wv_lay_q.delete(); wv_val_q.delete();
        bv_vec_q.delete(); bv_val_q.delete(); ni_q.delete();
        od_q.delete(); ol_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cfg_valid = 1'b0; cfg_data = '0;
        in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0; nrn_outvalid = '0; nrn_out = '0;
        repeat (3) step();
        rst = 1'b0;
    endtask

    task automatic send_cfg(input logic [DATA_W-1:0] w);
        bit acc = 0;
        cfg_valid = 1'b1;
        cfg_data  = w;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (cfg_ready) begin acc = 1; break; end
        end
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        if (!acc) begin
            checks++; failures++;
            $display("FAIL cfg_handshake: actual=no cfg_ready required=cfg_ready within 50 cycles");
        end
    endtask

    task automatic send_in(input logic [DATA_W-1:0] w);
        bit acc = 0;
        in_valid = 1'b1;
        in_data  = w;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready) begin acc = 1; break; end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (!acc) begin
            checks++; failures++;
            $display("FAIL in_handshake: actual=no in_ready required=in_ready within 50 cycles");
        end
    endtask

    task automatic load_words(input cfg_t words, input int first, input int count, input int max_gap);
        for (int j = first; j < first + count; j++) begin
            repeat ($urandom_range(0, max_gap)) step();
            send_cfg(words[j]);
        end
    endtask

    // Reference: word j belongs to neuron j/(NUM_IN+1); the last slot of each
    // group is that neuron's bias, the others are its weights in order.
    task automatic check_load(input cfg_t words, input string tag);
        int wi = 0;
        int bi = 0;
        repeat (3) step();
        checks++;
        if (wv_val_q.size() != NUM_NEURON*NUM_IN || bv_val_q.size() != NUM_NEURON) begin
            failures++;
            $display("FAIL %s_pulse_count: actual weight=%0d bias=%0d required weight=%0d bias=%0d",
                     tag, wv_val_q.size(), bv_val_q.size(), NUM_NEURON*NUM_IN, NUM_NEURON);
        end
        for (int j = 0; j < WORDS; j++) begin
            int n;
            logic [NUM_NEURON-1:0] ev;
            n = j / (NUM_IN + 1);
            if ((j % (NUM_IN + 1)) < NUM_IN) begin
                if (wi < wv_val_q.size()) begin
                    checks++;
                    if (wv_nrn_q[wi] !== SEL_W'(n) || wv_lay_q[wi] !== SEL_W'(LAYER_NO) || wv_val_q[wi] !== words[j]) begin
                        failures++;
                        $display("FAIL %s_weight[%0d]: actual nrn=%0d layer=%0d val=%h required nrn=%0d layer=%0d val=%h",
                                 tag, wi, wv_nrn_q[wi], wv_lay_q[wi], wv_val_q[wi], n, LAYER_NO, words[j]);
                    end
                end
                wi++;
            end else begin
                ev = '0;
                ev[n] = 1'b1;
                if (bi < bv_val_q.size()) begin
                    checks++;
                    if (bv_vec_q[bi] !== ev || bv_val_q[bi] !== words[j]) begin
                        failures++;
                        $display("FAIL %s_bias[%0d]: actual vec=%b val=%h required vec=%b val=%h",
                                 tag, bi, bv_vec_q[bi], bv_val_q[bi], ev, words[j]);
                    end
                end
                bi++;
            end
        end
        @(negedge clk);
        checks++;
        if (loaded !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_loaded: actual loaded=%b busy=%b required loaded=1 busy=0", tag, loaded, busy);
        end
        step();
    endtask

    // One vector: feed NUM_IN words (optional gap), stub neurons report in a
    // chosen order with arbitrary spacing, then drain and compare.
    task automatic do_vector(input vec_t vin, input int gap_pos, input int gap_len,
                             input act_t vout, input int first_nrn, input int hold,
                             input bit rand_ready, input string tag);
        int  order[NUM_NEURON];
        int  o;
        int  t;
        bit  ok;
        clear_logs();
        out_ready = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (i == gap_pos) repeat (gap_len) step();
            send_in(vin[i]);
        end
        // A further word offered now must not be taken.
        in_valid = 1'b1;
        in_data  = DATA_W'($urandom);
        ok = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (in_ready !== 1'b0 || busy !== 1'b1) ok = 0;
            step();
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_in_ready_after_vector: actual in_ready=%b busy=%b required in_ready=0 busy=1", tag, in_ready, busy);
        end
        checks++;
        if (ni_q.size() != NUM_IN) begin
            failures++;
            $display("FAIL %s_nrn_in_count: actual=%0d required=%0d", tag, ni_q.size(), NUM_IN);
        end
        for (int i = 0; i < NUM_IN && i < ni_q.size(); i++) begin
            checks++;
            if (ni_q[i] !== vin[i]) begin
                failures++;
                $display("FAIL %s_nrn_in[%0d]: actual=%h required=%h", tag, i, ni_q[i], vin[i]);
            end
        end

        order[0] = first_nrn;
        o = 1;
        for (int k = 0; k < NUM_NEURON; k++) if (k != first_nrn) begin order[o] = k; o++; end
        for (int p = 0; p < NUM_NEURON; p++) begin
            int k;
            k = order[p];
            if (p == NUM_NEURON - 1) begin
                @(negedge clk);
                checks++;
                if (out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL %s_out_valid_early: actual=%b required=0", tag, out_valid);
                end
                step();
            end
            nrn_out = BUS_W'($urandom);
            nrn_out[k*OUT_W +: OUT_W] = vout[k];
            nrn_outvalid = '0;
            nrn_outvalid[k] = 1'b1;
            step();
            nrn_outvalid = '0;
            nrn_out = BUS_W'($urandom);
            if (p < NUM_NEURON - 1) repeat ($urandom_range(0, 3)) step();
        end

        // Last report captured at the previous edge: one more edge to DRAIN.
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_drain_latency_early: actual out_valid=%b required=0", tag, out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== vout[0] || out_last !== 1'b0) begin
            failures++;
            $display("FAIL %s_drain_first: actual valid=%b data=%h last=%b required valid=1 data=%h last=0",
                     tag, out_valid, out_data, out_last, vout[0]);
        end
        step();
        if (hold > 0) begin
            ok = 1;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                if (out_valid !== 1'b1 || out_data !== vout[0] || in_ready !== 1'b0) ok = 0;
                step();
            end
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL %s_hold: actual valid=%b data=%h in_ready=%b required valid=1 data=%h in_ready=0",
                         tag, out_valid, out_data, in_ready, vout[0]);
            end
        end
        in_valid = 1'b0;

        t = 0;
        while (od_q.size() < NUM_NEURON && t < 200) begin
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            t++;
        end
        out_ready = 1'b0;
        checks++;
        if (od_q.size() != NUM_NEURON) begin
            failures++;
            $display("FAIL %s_drain_count: actual=%0d required=%0d", tag, od_q.size(), NUM_NEURON);
        end
        for (int k = 0; k < NUM_NEURON && k < od_q.size(); k++) begin
            checks++;
            if (od_q[k] !== vout[k] || ol_q[k] !== (k == NUM_NEURON - 1)) begin
                failures++;
                $display("FAIL %s_out[%0d]: actual data=%h last=%b required data=%h last=%b",
                         tag, k, od_q[k], ol_q[k], vout[k], (k == NUM_NEURON - 1));
            end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle_after_drain: actual busy=%b out_valid=%b required 0 0", tag, busy, out_valid);
        end
        step();
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({weight_valid, bias_valid, nrn_in_valid, out_valid, out_last} !== '0) begin
            failures++;
            $display("FAIL %s_strobes: actual wv=%b bv=%b niv=%b ov=%b ol=%b required all 0",
                     tag, weight_valid, bias_valid, nrn_in_valid, out_valid, out_last);
        end
        checks++;
        if (config_layer_num !== '0 || config_neuron_num !== '0) begin
            failures++;
            $display("FAIL %s_config_num: actual layer=%0d neuron=%0d required 0 0", tag, config_layer_num, config_neuron_num);
        end
        checks++;
        if (weight_value !== '0 || bias_value !== '0 || nrn_in_data !== '0 || out_data !== '0) begin
            failures++;
            $display("FAIL %s_data: actual w=%h b=%h ni=%h od=%h required all 0",
                     tag, weight_value, bias_value, nrn_in_data, out_data);
        end
        checks++;
        if ({loaded, busy, cfg_ready, in_ready} !== 4'b0000) begin
            failures++;
            $display("FAIL %s_flags: actual loaded=%b busy=%b cfg_ready=%b in_ready=%b required 0000",
                     tag, loaded, busy, cfg_ready, in_ready);
        end
    endtask

    function automatic cfg_t fixed_words();
        cfg_t w;
        for (int j = 0; j < WORDS; j++) w[j] = DATA_W'(j + 1);
        return w;
    endfunction

    function automatic cfg_t random_words();
        cfg_t w;
        for (int j = 0; j < WORDS; j++) w[j] = DATA_W'($urandom);
        return w;
    endfunction

    // ------------------------------------------------------------------------
    task automatic test_reset();
        @(negedge clk);
        check_all_zero("reset");
        step();
    endtask

    task automatic test_in_before_load();
        bit ok = 1;
        clear_logs();
        in_valid = 1'b1;
        in_data  = 16'hBEEF;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (in_ready !== 1'b0 || busy !== 1'b0) ok = 0;
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (!ok || ni_q.size() != 0) begin
            failures++;
            $display("FAIL in_before_load: actual in_ready=%b busy=%b pulses=%0d required 0 0 0", in_ready, busy, ni_q.size());
        end
    endtask

    task automatic test_load_fixed();
        cfg_t w = fixed_words();
        clear_logs();
        load_words(w, 0, WORDS, 0);
        check_load(w, "load_fixed");
    endtask

    task automatic test_vector_fixed();
        vec_t vin;
        act_t vout;
        for (int i = 0; i < NUM_IN; i++) vin[i] = DATA_W'($urandom);
        vout[0] = 8'h11; vout[1] = 8'h22; vout[2] = 8'h33;
        do_vector(vin, 2, 2, vout, 2, 5, 1'b0, "vector_fixed");
    endtask

    task automatic test_back_to_back();
        vec_t vin;
        act_t vout;
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < NUM_IN; i++) vin[i] = DATA_W'($urandom);
            for (int k = 0; k < NUM_NEURON; k++) vout[k] = OUT_W'($urandom);
            do_vector(vin, $urandom_range(0, NUM_IN), $urandom_range(0, 3), vout,
                      $urandom_range(0, NUM_NEURON - 1), $urandom_range(0, 2), 1'b1, "back_to_back");
        end
    endtask

    task automatic test_cfg_priority();
        cfg_t w = random_words();
        clear_logs();
        in_valid  = 1'b1;
        in_data   = DATA_W'($urandom);
        cfg_valid = 1'b1;
        cfg_data  = w[0];
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (cfg_ready !== 1'b1 || in_ready !== 1'b0 || loaded !== 1'b0) begin
            failures++;
            $display("FAIL cfg_priority: actual cfg_ready=%b in_ready=%b loaded=%b required 1 0 0", cfg_ready, in_ready, loaded);
        end
        step();
        in_valid  = 1'b0;
        cfg_valid = 1'b0;
        load_words(w, 1, WORDS - 1, 2);
        check_load(w, "cfg_priority_reload");
    endtask

    task automatic test_reset_mid_load();
        cfg_t w = fixed_words();
        load_words(w, 0, 7, 0);
        rst = 1'b1;
        step();
        @(negedge clk);
        check_all_zero("reset_mid_load");
        step();
        rst = 1'b0;
        clear_logs();
        load_words(w, 0, WORDS, 1);
        check_load(w, "reload_after_reset");
    endtask

    task automatic test_reset_after_load();
        bit ok = 1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (loaded !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) ok = 0;
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL reset_after_load: actual loaded=%b in_ready=%b busy=%b required 0 0 0", loaded, in_ready, busy);
        end
    endtask

    initial begin
        vec_t vin;
        act_t vout;
        do_reset();
        test_reset();
        test_in_before_load();
        test_load_fixed();
        test_vector_fixed();
        test_back_to_back();
        test_cfg_priority();
        for (int i = 0; i < NUM_IN; i++) vin[i] = DATA_W'($urandom);
        for (int k = 0; k < NUM_NEURON; k++) vout[k] = OUT_W'($urandom);
        do_vector(vin, NUM_IN, 0, vout, 1, 1, 1'b1, "after_reload");
        test_reset_mid_load();
        test_reset_after_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
